bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of one shared slave bus.
// The granted master's request is forwarded combinationally to the slave.
// Its completion is returned to that master in the same cycle as s_response.
// Optional feature: define ARBITER_TIMEOUT_EN to abort a granted transfer
// after TIMEOUT_CYCLES cycles without s_response. The abort returns
// 32'hDEADBEEF and pulses timeout_error.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [2:0]  m0_option,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  output logic [31:0] m0_read_data,
  output logic        m0_response,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [2:0]  m1_option,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  output logic [31:0] m1_read_data,
  output logic        m1_response,
  output logic        s_read,
  output logic        s_write,
  output logic [2:0]  s_option,
  output logic [31:0] s_address,
  output logic [31:0] s_write_data,
  input  logic [31:0] s_read_data,
  input  logic        s_response,
  output logic        timeout_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // Index of the master that most recently completed (or timed out).
  // Reset to 1 so that master 0 wins the first contention.
  logic   last_grant_q, last_grant_d;

  logic        req0, req1;
  logic        sel1;
  logic        g_read, g_write, g_req;
  logic [2:0]  g_option;
  logic [31:0] g_address, g_write_data;
  logic        finish;
  logic [31:0] rdata;

`ifdef ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  // cnt_q is 0 in the first grant cycle. Firing at TIMEOUT_CYCLES-1 bounds
  // the wait to exactly TIMEOUT_CYCLES cycles in the grant state.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Select the request fields of whichever master the grant state names.
  assign sel1         = (state_q == GRANT1);
  assign g_read       = sel1 ? m1_read       : m0_read;
  assign g_write      = sel1 ? m1_write      : m0_write;
  assign g_option     = sel1 ? m1_option     : m0_option;
  assign g_address    = sel1 ? m1_address    : m0_address;
  assign g_write_data = sel1 ? m1_write_data : m0_write_data;
  assign g_req        = g_read | g_write;

  // Next-state, bus forwarding and completion routing.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_option      = '0;
    s_address     = '0;
    s_write_data  = '0;
    timeout_error = 1'b0;
    finish        = 1'b0;
    rdata         = '0;
`ifdef ARBITER_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_grant_q)) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
`ifdef ARBITER_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      GRANT0, GRANT1: begin
        s_read       = g_read;
        s_write      = g_write;
        s_option     = g_option;
        s_address    = g_address;
        s_write_data = g_write_data;
        // A dropped request aborts silently. This takes priority over a
        // response that arrives in the same cycle.
        if (!g_req) begin
          state_d = IDLE;
        end else if (s_response) begin
          finish = 1'b1;
          rdata  = s_read_data;
        end
`ifdef ARBITER_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          finish        = 1'b1;
          rdata         = 32'hDEADBEEF;
          timeout_error = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
        if (finish) begin
          state_d      = IDLE;
          last_grant_d = sel1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_response  = finish & ~sel1;
  assign m1_response  = finish & sel1;
  assign m0_read_data = (finish && !sel1) ? rdata : '0;
  assign m1_read_data = (finish && sel1)  ? rdata : '0;

  // State, round-robin pointer and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
`ifdef ARBITER_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
`ifdef ARBITER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus for bus_arbiter.
// An ownership model predicts every output on each falling edge.
// Literal checks pin the key scenarios.
module tb_bus_arbiter;

  localparam int TO = 4;
`ifdef ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [2:0]  m0_option, m1_option;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_response, m1_response;
  logic        s_read, s_write;
  logic [2:0]  s_option;
  logic [31:0] s_address, s_write_data, s_read_data;
  logic        s_response;
  logic        timeout_error;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_log[$];

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_option(m0_option),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_read_data(m0_read_data), .m0_response(m0_response),
    .m1_read(m1_read), .m1_write(m1_write), .m1_option(m1_option),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_read_data(m1_read_data), .m1_response(m1_response),
    .s_read(s_read), .s_write(s_write), .s_option(s_option),
    .s_address(s_address), .s_write_data(s_write_data),
    .s_read_data(s_read_data), .s_response(s_response),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  // Model: who owns the bus (-1 = nobody), who finished last, cycles spent owning.
  int owner  = -1;
  int last   = 1;
  int waited = 0;
  bit mr0, mr1, own_req;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner = -1; last = 1; waited = 0;
    end else begin
      mr0 = m0_read | m0_write;
      mr1 = m1_read | m1_write;
      if (owner < 0) begin
        if (mr0 && mr1) owner = (last == 0) ? 1 : 0;
        else if (mr0)   owner = 0;
        else if (mr1)   owner = 1;
        waited = 1;
      end else begin
        own_req = (owner == 0) ? mr0 : mr1;
        if (!own_req) owner = -1;
        else if (s_response || (TO_EN && waited == TO)) begin
          last = owner; owner = -1;
        end else waited++;
      end
    end
  end

  function automatic logic [135:0] model_vec();
    logic sr, sw, r0, r1, te, rq;
    logic [2:0] so;
    logic [31:0] sa, swd, r0d, r1d, rd;
    sr = 0; sw = 0; so = 0; sa = 0; swd = 0;
    r0 = 0; r1 = 0; r0d = 0; r1d = 0; te = 0; rd = 0;
    if (reset === 1'b1 && owner >= 0) begin
      if (owner == 0) begin
        sr = m0_read; sw = m0_write; so = m0_option; sa = m0_address; swd = m0_write_data;
      end else begin
        sr = m1_read; sw = m1_write; so = m1_option; sa = m1_address; swd = m1_write_data;
      end
      rq = sr | sw;
      if (rq && (s_response || (TO_EN && waited == TO))) begin
        if (s_response) rd = s_read_data;
        else begin rd = 32'hDEADBEEF; te = 1; end
        if (owner == 0) begin r0 = 1; r0d = rd; end
        else begin r1 = 1; r1d = rd; end
      end
    end
    return {sr, sw, so, sa, swd, r0, r0d, r1, r1d, te};
  endfunction

  logic [135:0] got_v, exp_v;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    got_v = {s_read, s_write, s_option, s_address, s_write_data,
             m0_response, m0_read_data, m1_response, m1_read_data, timeout_error};
    exp_v = model_vec();
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_check t=%0t got=%h exp=%h", $time, got_v, exp_v);
    end
    if (m0_response === 1'b1) resp_log.push_back(0);
    if (m1_response === 1'b1) resp_log.push_back(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m0_option = 3'b000; m0_address = 0; m0_write_data = 0;
    m1_read = 0; m1_write = 0; m1_option = 3'b000; m1_address = 0; m1_write_data = 0;
    s_response = 0; s_read_data = 32'hAAAA5555;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    repeat (2) cyc();
    reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    do_reset();
    mid();
    chk("reset_s_read", {31'd0, s_read}, 32'd0);
    chk("reset_timeout", {31'd0, timeout_error}, 32'd0);

    // Single read from master 0: request cycle, then grant cycle with response.
    m0_read = 1; m0_address = 32'h10; m0_option = 3'b010;
    mid();
    chk("t1_idle_resp", {31'd0, m0_response}, 32'd0);
    cyc();
    s_response = 1; s_read_data = 32'h12345678;
    mid();
    chk("t1_resp", {31'd0, m0_response}, 32'd1);
    chk("t1_rdata", m0_read_data, 32'h12345678);
    chk("t1_addr", s_address, 32'h10);
    cyc();
    m0_read = 0; s_response = 0; s_read_data = 32'hAAAA5555;
    mid();
    chk("t1_back_idle", {31'd0, s_read}, 32'd0);

    // Both masters hold requests from reset: alternating grants.
    do_reset();
    resp_log.delete();
    m0_read = 1; m0_address = 32'h100; m1_read = 1; m1_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      cyc();
      s_response = 1;
      mid();
      chk("t2_addr", s_address, (k % 2 == 0) ? 32'h100 : 32'h200);
      cyc();
      s_response = 0;
    end
    m0_read = 0; m1_read = 0;
    mid();
    chk("t2_count", resp_log.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("t2_order", (k < resp_log.size()) ? resp_log[k] : -1, k % 2);

    // Master 1 write in progress while master 0 requests.
    m1_write = 1; m1_address = 32'h1000; m1_write_data = 32'hCAFEF00D;
    cyc();
    m0_read = 1; m0_address = 32'h44;
    mid();
    chk("t3_addr_a", s_address, 32'h1000);
    cyc();
    mid();
    chk("t3_addr_b", s_address, 32'h1000);
    chk("t3_wdata", s_write_data, 32'hCAFEF00D);
    cyc();
    s_response = 1;
    mid();
    chk("t3_m1_resp", {31'd0, m1_response}, 32'd1);
    chk("t3_m0_quiet", {31'd0, m0_response}, 32'd0);
    cyc();
    m1_write = 0; s_response = 0;
    mid();
    chk("t3_idle", {31'd0, s_read}, 32'd0);
    cyc();
    s_response = 1;
    mid();
    chk("t3_m0_addr", s_address, 32'h44);
    chk("t3_m0_resp", {31'd0, m0_response}, 32'd1);
    cyc();
    m0_read = 0; s_response = 0;

    // Master 0 aborts; pending master 1 gets the bus next.
    m0_read = 1; m0_address = 32'h400;
    cyc();
    m1_read = 1; m1_address = 32'h500;
    mid();
    chk("t4_addr0", s_address, 32'h400);
    cyc();
    m0_read = 0;
    mid();
    chk("t4_no_resp", {31'd0, m0_response}, 32'd0);
    cyc();
    mid();
    chk("t4_idle", {31'd0, s_read}, 32'd0);
    cyc();
    s_response = 1;
    mid();
    chk("t4_addr1", s_address, 32'h500);
    chk("t4_m1_resp", {31'd0, m1_response}, 32'd1);
    cyc();
    m1_read = 0; s_response = 0;

    // Reset in the middle of a master 1 grant.
    m1_write = 1; m1_address = 32'h2000; m1_write_data = 32'h5A5A5A5A;
    cyc();
    #2;
    chk("t5_write_before", {31'd0, s_write}, 32'd1);
    reset = 0; s_response = 1;
    #1;
    chk("t5_write_dropped", {31'd0, s_write}, 32'd0);
    chk("t5_no_resp", {31'd0, m1_response}, 32'd0);
    mid();
    cyc();
    m1_write = 0; s_response = 0; reset = 1;
    mid();
    chk("t5_idle", {31'd0, s_write}, 32'd0);

    // After that reset, contention goes to master 0 first.
    m0_read = 1; m0_address = 32'h600; m1_read = 1; m1_address = 32'h700;
    cyc();
    s_response = 1;
    mid();
    chk("t6_m0_first", {31'd0, m0_response}, 32'd1);
    chk("t6_m1_wait", {31'd0, m1_response}, 32'd0);
    cyc();
    m0_read = 0; m1_read = 0; s_response = 0;
    mid();

`ifdef ARBITER_TIMEOUT_EN
    // Slave never answers master 0: abort in the fourth grant cycle.
    m0_read = 1; m0_address = 32'h300;
    cyc();
    for (int k = 1; k <= TO; k++) begin
      mid();
      chk("t7_timeout_flag", {31'd0, timeout_error}, (k == TO) ? 32'd1 : 32'd0);
      if (k < TO) cyc();
    end
    chk("t7_resp", {31'd0, m0_response}, 32'd1);
    chk("t7_rdata", m0_read_data, 32'hDEADBEEF);
    cyc();
    m0_read = 0;
    mid();
    chk("t7_idle", {31'd0, s_read}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
